or_accel_seq: RTL and testbench

- Bus-master sequencer directly upstream of the memory-mapped bitwise-OR accelerator.
- Accepts an operand pair on a valid/ready command port and writes operand A (offset 0x00), then operand B (offset 0x08), then reads the result (offset 0x10).
- Returns the read data on a valid/ready result port.
- Hides the accelerator's register map and one-cycle-rvalid protocol from the core-side logic.

---
 rtl/or_accel_seq.sv | 125 ++++++++++++
 tb/tb_or_accel_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/or_accel_seq.sv
// or_accel_seq: bus-master sequencer for the memory-mapped bitwise-OR accelerator.
//   Takes an operand pair from the command port, writes A (BASE+0x00) and B (BASE+0x08),
//   reads the result (BASE+0x10) and returns it on the result port.
//   A wait for acc_rvalid_i that exceeds TIMEOUT_CYCLES aborts with res_err_o=1.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o/cmd_a_i/cmd_b_i      command handshake and operands
//   res_valid_o/res_ready_i/res_data_o/res_err_o result handshake, data and abort flag
//   acc_req_o/acc_we_o/acc_be_o/acc_addr_o/acc_wdata_o  accelerator request
//   acc_rvalid_i/acc_rdata_i             accelerator response, one cycle after each request
// Optional: define OR_ACCEL_SEQ_OPCACHE_EN to skip rewriting operands that the
//   accelerator already holds.
module or_accel_seq #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_data_o,
  output logic        res_err_o,
  output logic        acc_req_o,
  output logic        acc_we_o,
  output logic [3:0]  acc_be_o,
  output logic [31:0] acc_addr_o,
  output logic [31:0] acc_wdata_o,
  input  logic        acc_rvalid_i,
  input  logic [31:0] acc_rdata_i
);
  typedef enum logic [2:0] {IDLE, WR_A, WT_A, WR_B, WT_B, RD_C, WT_C, RESP} state_t;
  state_t state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] a_q, b_q, data_q;
  logic        err_q;
  logic        wt, timeout, abort;
  logic        hit_a, hit_b_cmd, hit_b_lat;
  assign wt      = state_q inside {WT_A, WT_B, WT_C};
  assign timeout = cnt_q == 8'(TIMEOUT_CYCLES - 1);
  // a response in the last permitted wait cycle still wins over the timeout
  assign abort   = wt && !acc_rvalid_i && timeout;
`ifdef OR_ACCEL_SEQ_OPCACHE_EN
  logic [31:0] ca_q, cb_q;
  logic        ca_v, cb_v;
  assign hit_a     = ca_v && ca_q == cmd_a_i;
  assign hit_b_cmd = cb_v && cb_q == cmd_b_i;
  // after writing A, B is checked against the latched operand
  assign hit_b_lat = cb_v && cb_q == b_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || abort) begin
      ca_v <= 1'b0;
      cb_v <= 1'b0;
      ca_q <= '0;
      cb_q <= '0;
    end else begin
      if (state_q == WT_A && acc_rvalid_i) begin
        ca_v <= 1'b1;
        ca_q <= a_q;
      end
      if (state_q == WT_B && acc_rvalid_i) begin
        cb_v <= 1'b1;
        cb_q <= b_q;
      end
    end
  end
`else
  assign hit_a     = 1'b0;
  assign hit_b_cmd = 1'b0;
  assign hit_b_lat = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid_i) state_d = hit_a ? (hit_b_cmd ? RD_C : WR_B) : WR_A;
      WR_A: state_d = WT_A;
      WR_B: state_d = WT_B;
      RD_C: state_d = WT_C;
      WT_A: state_d = acc_rvalid_i ? (hit_b_lat ? RD_C : WR_B) : timeout ? RESP : WT_A;
      WT_B: state_d = acc_rvalid_i ? RD_C : timeout ? RESP : WT_B;
      WT_C: state_d = (acc_rvalid_i || timeout) ? RESP : WT_C;
      RESP: if (res_ready_i) state_d = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready_o = state_q == IDLE;
    res_valid_o = state_q == RESP;
    res_data_o  = data_q;
    res_err_o   = err_q;
    acc_req_o   = state_q inside {WR_A, WR_B, RD_C};
    acc_we_o    = state_q inside {WR_A, WR_B};
    acc_be_o    = acc_req_o ? 4'hF : 4'h0;
    acc_addr_o  = state_q == WR_A ? BASE_ADDR :
                  state_q == WR_B ? BASE_ADDR + 32'h08 :
                  state_q == RD_C ? BASE_ADDR + 32'h10 : 32'h0;
    acc_wdata_o = state_q == WR_A ? a_q : state_q == WR_B ? b_q : 32'h0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (wt && state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
      if (state_q == IDLE && cmd_valid_i) begin
        a_q <= cmd_a_i;
        b_q <= cmd_b_i;
      end
      if (state_q == WT_C && acc_rvalid_i) begin
        data_q <= acc_rdata_i;
        err_q  <= 1'b0;
      end else if (abort) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_or_accel_seq.sv
// tb_or_accel_seq: randomized self-checking bench for or_accel_seq against an accelerator model.
module tb_or_accel_seq;
  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int          TO   = 16;
`ifdef OR_ACCEL_SEQ_OPCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  typedef logic [68:0] txn_t;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_a_i = '0;
  logic [31:0] cmd_b_i = '0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b1;
  logic [31:0] res_data_o;
  logic        res_err_o;
  logic        acc_req_o;
  logic        acc_we_o;
  logic [3:0]  acc_be_o;
  logic [31:0] acc_addr_o;
  logic [31:0] acc_wdata_o;
  logic        acc_rvalid_i = 1'b0;
  logic [31:0] acc_rdata_i = '0;
  int          n_chk = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned last_hs = 0;
  bit          follow = 1'b0;
  bit          mute = 1'b0;
  bit          m_av = 1'b0;
  bit          m_bv = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] ra = '0;
  logic [31:0] rb = '0;
  txn_t        bus_q[$];
  or_accel_seq #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_err_o(res_err_o),
    .acc_req_o(acc_req_o), .acc_we_o(acc_we_o), .acc_be_o(acc_be_o), .acc_addr_o(acc_addr_o),
    .acc_wdata_o(acc_wdata_o), .acc_rvalid_i(acc_rvalid_i), .acc_rdata_i(acc_rdata_i)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  // accelerator: two operand registers, the result register reads back their OR
  always @(posedge clk_i) begin
    acc_rvalid_i <= acc_req_o && !mute;
    acc_rdata_i  <= (acc_req_o && !acc_we_o && acc_addr_o == BASE + 32'h10) ? (ra | rb) : 32'h0;
    if (acc_req_o && acc_we_o && acc_addr_o == BASE) ra <= acc_wdata_o;
    if (acc_req_o && acc_we_o && acc_addr_o == BASE + 32'h08) rb <= acc_wdata_o;
    if (acc_req_o) bus_q.push_back({acc_be_o, acc_we_o, acc_addr_o, acc_wdata_o});
  end
  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // one command through to its result handshake; pend keeps cmd_valid_i high with (na, nb)
  task automatic xact(input logic [31:0] a, input logic [31:0] b, input int stall,
                      input bit dead, input bit pend, input logic [31:0] na, input logic [31:0] nb);
    txn_t        exp_q[$];
    int          k, lat;
    int unsigned t_acc;
    bit          busy_bad, stall_bad;
    logic [31:0] exp_data;
    busy_bad    = 1'b0;
    stall_bad   = 1'b0;
    exp_data    = dead ? 32'h0 : (a | b);
    cmd_valid_i = 1'b1;
    cmd_a_i     = a;
    cmd_b_i     = b;
    res_ready_i = stall == 0;
    mute        = dead;
    k = 0;
    while (!cmd_ready_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    check("cmd_accept", k < 20, 1);
    @(posedge clk_i);
    #1;
    t_acc = cyc;
    bus_q.delete();
    if (follow) check("accept_gap", t_acc - last_hs, 1);
    if (!(CACHE && m_av && m_a == a)) exp_q.push_back({4'hF, 1'b1, BASE, a});
    if (!(CACHE && m_bv && m_b == b)) exp_q.push_back({4'hF, 1'b1, BASE + 32'h08, b});
    exp_q.push_back({4'hF, 1'b0, BASE + 32'h10, 32'h0});
    if (dead) begin
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      lat = 2 + TO;
    end else lat = 2 * exp_q.size() + 1;
    @(negedge clk_i);
    if (pend) begin
      cmd_a_i = na;
      cmd_b_i = nb;
    end else cmd_valid_i = 1'b0;
    k = 1;
    while (!res_valid_o && k < 100) begin
      if (cmd_ready_o) busy_bad = 1'b1;
      @(negedge clk_i);
      k++;
    end
    mute = 1'b0;
    check("latency", k, lat);
    check("busy_ready", busy_bad, 0);
    check("res_data", res_data_o, exp_data);
    check("res_err", res_err_o, dead);
    for (int i = 0; i < stall; i++) begin
      if (!res_valid_o || acc_req_o || cmd_ready_o || res_data_o !== exp_data || res_err_o !== dead)
        stall_bad = 1'b1;
      @(negedge clk_i);
    end
    res_ready_i = 1'b1;
    if (stall > 0) check("stall_hold", stall_bad, 0);
    @(posedge clk_i);
    #1;
    last_hs = cyc;
    check("res_drop", {res_valid_o, cmd_ready_o}, 2'b01);
    check("bus_len", bus_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check("bus_txn", i < bus_q.size() ? bus_q[i] : 69'h0, exp_q[i]);
    if (dead) begin
      m_av = 1'b0;
      m_bv = 1'b0;
    end else begin
      m_av = 1'b1;
      m_a  = a;
      m_bv = 1'b1;
      m_b  = b;
    end
    follow = pend;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] pa[5], pb[5];
    logic [31:0] qa[13], qb[13];
    bit          pd;
    cmd_valid_i = 1'b1;
    cmd_a_i     = 32'hDEAD_BEEF;
    cmd_b_i     = 32'h1234_5678;
    repeat (2) @(negedge clk_i);
    check("rst_ctl", {acc_req_o, acc_we_o, acc_be_o}, 0);
    check("rst_addr", acc_addr_o, 0);
    check("rst_wdata", acc_wdata_o, 0);
    check("rst_res", {res_valid_o, res_err_o, res_data_o}, 0);
    check("rst_ready", cmd_ready_o, 1);
    rst_i       = 1'b0;
    cmd_valid_i = 1'b0;
    // basic
    xact(32'hF0F0_0000, 32'h0000_0F0F, 0, 0, 0, 0, 0);
    // backpressure with a second command pending
    xact(32'h1357_0000, 32'h0000_2468, 5, 0, 1, 32'hA0A0_A0A0, 32'h0505_0505);
    xact(32'hA0A0_A0A0, 32'h0505_0505, 0, 0, 0, 0, 0);
    // timeout on the first request
    xact(32'h0BAD_0000, 32'h0000_F00D, 0, 1, 0, 0, 0);
    // reset while waiting for B's write response
    cmd_valid_i = 1'b1;
    cmd_a_i     = 32'h0F00_0000;
    cmd_b_i     = 32'h0000_00F0;
    @(posedge clk_i);
    #1;
    bus_q.delete();
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("pre_rst_bus", bus_q.size(), 2);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("midrst_acc", {acc_req_o, acc_we_o, acc_be_o, res_valid_o}, 0);
    check("midrst_addr", {acc_addr_o, acc_wdata_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_ready", cmd_ready_o, 1);
    m_av   = 1'b0;
    m_bv   = 1'b0;
    follow = 1'b0;
    xact(32'h0F00_0000, 32'h0000_00F0, 0, 0, 0, 0, 0);
    // repeated operands
    xact(32'h1, 32'h2, 0, 0, 0, 0, 0);
    xact(32'h1, 32'h2, 0, 0, 0, 0, 0);
    // back-to-back with cmd_valid_i held high
    for (int i = 0; i < 5; i++) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    for (int i = 0; i < 4; i++) xact(pa[i], pb[i], 0, 0, i < 3, pa[i+1], pb[i+1]);
    // random mix, sometimes reusing earlier operands
    qa[0] = $urandom;
    qb[0] = $urandom;
    for (int i = 1; i < 13; i++) begin
      qa[i] = ($urandom_range(0, 2) == 0) ? qa[i-1] : $urandom;
      qb[i] = ($urandom_range(0, 2) == 0) ? qb[i-1] : $urandom;
    end
    pd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pd = $urandom_range(0, 1) == 1;
      xact(qa[i], qb[i], $urandom_range(0, 3), $urandom_range(0, 7) == 0, pd, qa[i+1], qb[i+1]);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
